fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage sitting directly upstream of the IF/ID boundary of the pipelined CPU. Owns the program counter, drives the instruction-memory address, and buffers fetched instructions in a small queue so decode can stall on hazards without losing or refetching instructions. Branch/jump redirects from later stages flush the queue and reload the PC. Decode consumes instructions through a valid/ready handshake.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- DEPTH, 2: queue entries; power of two, ≥2.
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  fetch enable; low pauses fetching, queue still drains.
- imem_addr_o  out  32  instruction-memory address; equals the current PC.
- imem_instr_i  in  32  instruction word; combinational read of imem_addr_o in the same cycle.
- redirect_i  in  1  taken branch/jump; flush and reload PC.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and forced to 0.
- id_ready_i  in  1  decode accepts the head entry this cycle (low = hazard stall).
- id_valid_o  out  1  head entry valid.
- id_instr_o  out  32  head instruction; 32'h0 when empty.
- id_pc4_o  out  32  PC+4 of the head instruction; 32'h0 when empty.
- fetch_pc_o  out  32  current PC (same as imem_addr_o).
- count_o  out  log2(DEPTH)+1  queue occupancy.

## Operation
- State: PC register; circular queue of DEPTH entries {pc4, instr} with read pointer, write pointer and occupancy counter.
- pop = id_valid_o & id_ready_i.
- push = start_i & ~redirect_i & (count_o < DEPTH | pop). A full queue with a simultaneous pop accepts the push.
- On push: write {PC+4, imem_instr_i} at the write pointer, PC <= PC+4.
- On pop: advance the read pointer.
- Occupancy update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Redirect has priority over everything except reset:
  - queue cleared (count 0, pointers 0);
  - PC <= {redirect_pc_i[31:2], 2'b00};
  - no push that cycle.
  - A pop coincident with redirect still counts as accepted by decode, but has no effect on the queue since it is cleared.
- start_i low: PC holds, no push, pops proceed normally.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 and stores pc4 = 32'h0.
- id_valid_o = (count_o != 0). id_instr_o and id_pc4_o show the head entry when valid and are forced to zero when empty, so decode sees a NOP.
- Pointers wrap modulo DEPTH.
- Reset (rst_i low at an edge, including mid-operation) overrides redirect, push and pop:
  - PC = RESET_PC, queue empty, count_o = 0, id_valid_o = 0, id_instr_o = 0, id_pc4_o = 0;
  - imem_addr_o and fetch_pc_o equal RESET_PC.

## Timing
- Fetch at cycle n (push) appears at the id_* outputs in cycle n+1 if the queue was empty. Otherwise it appears after the entries ahead of it are popped.
- With id_ready_i held high and start_i high, throughput is 1 instruction per cycle and occupancy stays at 1.
- A stall of k cycles fills the queue after DEPTH−1 further fetches. While the queue is full, the PC freezes.
- After id_ready_i reasserts, the first pop and a new push happen in the same cycle, with no bubble.
- Redirect in cycle n:
  - cycle n+1: id_valid_o = 0, fetch_pc_o = target;
  - the target instruction is visible in cycle n+2.
- Redirect penalty is one bubble cycle at decode.
- No combinational path from id_ready_i to imem_addr_o. Paths from id_ready_i to internal push enable are allowed.
- All outputs are registered or derived from registered state, except imem_addr_o, which is driven straight from the PC register.

## Test plan
1. Reset release then start_i = 1, ready = 1, imem returns instr = addr ^ 32'hA5A5_0000 → id_valid_o rises in the cycle after the first fetch. id_pc4_o then steps 4, 8, 12, … with matching id_instr_o; count_o stays 1.
2. Hold id_ready_i = 0 for 4 cycles after streaming starts → count_o reaches 2, fetch_pc_o freezes, head stays at pc4 = 8. After release, the pc4 sequence resumes 8, 12, 16, … with no gaps or duplicates.
3. Queue full (count 2) with ready = 1 and start_i = 1 → pop and push in the same cycle, count_o stays 2, PC advances by 4.
4. Redirect_i with queue full, redirect_pc_i = 32'h0000_0103 → next cycle count_o = 0, id_valid_o = 0, id_instr_o = 0, fetch_pc_o = 32'h0000_0100. The following cycle shows id_pc4_o = 32'h0000_0104.
5. Redirect to 32'hFFFF_FFFC → head pc4 = 32'h0000_0000 and fetch_pc_o wraps to 32'h0000_0000. Separately, start_i = 0 → PC holds and the queue drains to empty.
6. rst_i driven low for one edge while count_o = 2 and redirect_i = 1 → next cycle all outputs at reset values with fetch_pc_o = RESET_PC. Fetching restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Groups the buses of the fetch stage: the instruction-memory port and the
// valid/ready handshake towards decode.
//   imem_addr_o   fetch stage -> imem    instruction address (current PC)
//   imem_instr_i  imem -> fetch stage    instruction word, combinational read
//   id_valid_o    fetch stage -> decode  head entry valid
//   id_instr_o    fetch stage -> decode  head instruction (zero when empty)
//   id_pc4_o      fetch stage -> decode  PC+4 of head instruction (zero when empty)
//   id_ready_i    decode -> fetch stage  decode accepts the head entry
// master = fetch stage side, slave = memory/decode side.
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc4_o;
  logic        id_ready_i;

  modport master (
    output imem_addr_o,
    input  imem_instr_i,
    output id_valid_o,
    output id_instr_o,
    output id_pc4_o,
    input  id_ready_i
  );

  modport slave (
    input  imem_addr_o,
    output imem_instr_i,
    input  id_valid_o,
    input  id_instr_o,
    input  id_pc4_o,
    output id_ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the PC, drives the instruction-memory address
// and buffers fetched {pc4, instr} pairs in a DEPTH-entry circular queue so
// decode can stall without losing or refetching instructions. A redirect
// flushes the queue and reloads the PC; reset overrides everything.
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-low reset
//   start_i        fetch enable; low pauses fetching, the queue still drains
//   redirect_i     taken branch/jump: flush queue, reload PC
//   redirect_pc_i  redirect target, bits [1:0] forced to zero
//   fetch_pc_o     current PC
//   count_o        queue occupancy
//   bus            imem port and decode handshake (fetch_stage_if.master)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic [31:0]                fetch_pc_o,
  output logic [$clog2(DEPTH):0]     count_o,
  fetch_stage_if.master              bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_pc4   [DEPTH];
  logic [31:0]   r_q_instr [DEPTH];

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic [31:0] w_pc4;
  logic [31:0] w_redirect_pc;

  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid & bus.id_ready_i;
  // A full queue still accepts a fetch when decode frees the head this cycle.
  assign w_push        = start_i & ~redirect_i & ((r_count < CW'(DEPTH)) | w_pop);
  assign w_pc4         = r_pc + 32'd4;
  assign w_redirect_pc = redirect_pc_i & ~32'h0000_0003;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_pc     <= w_redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= w_pc4;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue storage is not reset; an entry is only visible once the
  // occupancy counter covers it, so stale contents are never presented.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_pc4[r_wr_ptr]   <= w_pc4;
      r_q_instr[r_wr_ptr] <= bus.imem_instr_i;
    end
  end

  assign bus.imem_addr_o = r_pc;
  assign fetch_pc_o      = r_pc;
  assign count_o         = r_count;
  assign bus.id_valid_o  = w_valid;
  // Empty queue presents all-zero words so decode sees a NOP.
  assign bus.id_instr_o  = w_valid ? r_q_instr[r_rd_ptr] : 32'h0;
  assign bus.id_pc4_o    = w_valid ? r_q_pc4[r_rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Drives fetch_stage with directed phases followed by randomized traffic.
// A reference model tracks the PC and the buffered instructions as a plain
// queue; every instruction decode should receive is pushed onto an expected
// queue, and an independent monitor pops and compares it whenever the DUT
// completes a valid/ready handshake.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] SALT     = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic [1:0]  count;

  fetch_stage_if bus ();

  // Instruction memory: every word is its own address xor a salt.
  assign bus.imem_instr_i = bus.imem_addr_o ^ SALT;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .start_i       (start),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .fetch_pc_o    (fetch_pc),
    .count_o       (count),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  entry_t      ref_q[$];
  entry_t      exp_q[$];
  logic [31:0] m_pc;
  bit          known;
  bit          pre_known;
  int          pre_count;
  logic [31:0] pre_pc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the reference model, evaluated just before the rising edge
  // with the inputs that the DUT will sample.
  task automatic model_step();
    bit pop;
    pre_known = known;
    pre_count = ref_q.size();
    pre_pc    = m_pc;
    pop       = known && (ref_q.size() != 0) && bus.id_ready_i;
    if (pop) begin
      exp_q.push_back(ref_q[0]);
      ref_q.pop_front();
    end
    if (!rst_n) begin
      ref_q.delete();
      m_pc  = RESET_PC;
      known = 1'b1;
    end else if (known && redirect) begin
      ref_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (known && start && ref_q.size() < DEPTH) begin
      ref_q.push_back('{pc4: m_pc + 32'd4, instr: m_pc ^ SALT});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive(input int n, input bit st, input bit rdy, input bit rd,
                       input logic [31:0] rpc, input bit rn);
    repeat (n) begin
      @(negedge clk);
      start          = st;
      bus.id_ready_i = rdy;
      redirect       = rd;
      redirect_pc    = rpc;
      rst_n          = rn;
      #3 model_step();
    end
  endtask

  // Monitor: compares the DUT's pre-edge outputs each cycle and retires
  // expected instructions on every observed handshake.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (pre_known) begin
        check("count", 32'(count), 32'(pre_count));
        check("fetch_pc", fetch_pc, pre_pc);
        check("imem_addr", bus.imem_addr_o, pre_pc);
        check("id_valid", 32'(bus.id_valid_o), 32'(pre_count != 0));
        if (bus.id_valid_o && bus.id_ready_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pop", 32'(1), 32'(0));
          end else begin
            check("id_pc4", bus.id_pc4_o, exp_q[0].pc4);
            check("id_instr", bus.id_instr_o, exp_q[0].instr);
            exp_q.pop_front();
          end
        end else if (!bus.id_valid_o) begin
          check("empty_pc4", bus.id_pc4_o, 32'h0);
          check("empty_instr", bus.id_instr_o, 32'h0);
        end
        if (exp_q.size() != 0) begin
          check("missed_pop", 32'(exp_q.size()), 32'(0));
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    bus.id_ready_i = 1'b0;
    m_pc           = RESET_PC;
    known          = 1'b0;
    pre_known      = 1'b0;

    drive(2, 0, 0, 0, 32'h0, 0);            // reset
    drive(6, 1, 1, 0, 32'h0, 1);            // stream at one per cycle
    drive(4, 1, 0, 0, 32'h0, 1);            // decode stall fills the queue
    drive(4, 1, 1, 0, 32'h0, 1);            // release: pop and push together
    drive(3, 1, 0, 0, 32'h0, 1);            // refill
    drive(1, 1, 1, 1, 32'h0000_0103, 1);    // redirect with full queue
    drive(3, 1, 1, 0, 32'h0, 1);
    drive(1, 1, 0, 1, 32'hFFFF_FFFC, 1);    // redirect to top of address space
    drive(3, 1, 1, 0, 32'h0, 1);
    drive(4, 0, 1, 0, 32'h0, 1);            // fetch paused, queue drains
    drive(3, 1, 0, 0, 32'h0, 1);            // fill
    drive(1, 1, 1, 1, 32'h0000_0200, 0);    // reset beats redirect
    drive(4, 1, 1, 0, 32'h0, 1);            // restart from RESET_PC

    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive(1,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            rpc,
            $urandom_range(0, 63) != 0);
    end

    drive(5, 0, 1, 0, 32'h0, 1);            // drain
    #2;
    check("final_ref_empty", 32'(ref_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
